// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive parsers: state encodings, frame
// field constants and the byte-wide CRC-32 / saturating-counter helpers.
package gmii_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PRE     = 4'd1,
        ST_ETH     = 4'd2,
        ST_IP      = 4'd3,
        ST_UDP     = 4'd4,
        ST_TYPE    = 4'd5,
        ST_RESOL   = 4'd6,
        ST_PAYLOAD = 4'd7,
        ST_FCS     = 4'd8,
        ST_END     = 4'd9,
        ST_DROP    = 4'd10
    } rx_state_t;

    localparam logic [7:0]  PKT_VIDEO    = 8'h00;
    localparam logic [7:0]  PKT_AUDIO    = 8'h01;
    localparam logic [7:0]  PKT_VIDAX    = 8'h02;

    localparam logic [7:0]  PREAMBLE     = 8'h55;
    localparam logic [7:0]  SFD          = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IP = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROT_UDP  = 8'h11;

    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    // MSB-first CRC-32 step; Ethernet sends each octet LSB first, so bit 0
    // of the data byte is shifted in first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Octet idx (0 = first on the wire) of a 48-bit MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

    // Octet idx (0 = first on the wire) of an IPv4 address.
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        case (idx)
            2'd0:    return ip[31:24];
            2'd1:    return ip[23:16];
            2'd2:    return ip[15:8];
            default: return ip[7:0];
        endcase
    endfunction

endpackage

// File: rtl/crc32_chk.sv
// Byte-wide Ethernet CRC-32 checker. Running over a frame including its FCS
// leaves a fixed residue in the register when the frame is intact.
module crc32_chk
    import gmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] data,
    output logic       crc_ok
);

    logic [31:0] crc_r;

    // CRC register: preset at frame start, advanced one octet per enable.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_r <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc_r <= crc32_byte(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_ok = (crc_r == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx_video.sv
// GMII receive parser for UDP video frames: strips preamble and headers,
// checks addressing and FCS, and writes {line, x, Y, C} words to the line FIFO.
module gmii_rx_video
    import gmii_pkg::*;
#(
    parameter logic [47:0] MY_MAC      = 48'h002345678902,
    parameter logic [31:0] MY_IP       = {8'd192, 8'd168, 8'd0, 8'd2},
    parameter logic [15:0] UDP_PORT    = 16'd12345,
    parameter logic [10:0] PAYLOAD_LEN = 11'd1280,
    parameter logic [10:0] LINE_MAX    = 11'd719
)
(
    input  logic        rx_clk,
    input  logic        sys_rst,
    input  logic        id,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    input  logic        full,
    output logic        wr_en,
    output logic [37:0] din,
    output logic        pkt_end,
    output logic        pkt_ok,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] aux_cnt
);

    logic        dv_r, er_r, full_r, id_r;
    logic [7:0]  d_r;
    rx_state_t   state_r, state_n_s;
    logic [10:0] cnt_r, x_r, line_r;
    logic [2:0]  line_hi_r;
    logic [7:0]  y_r;
    logic        ovf_r, extra_r;
    logic        wr_en_r, pkt_end_r, pkt_ok_r;
    logic [37:0] din_r;
    logic [15:0] crc_err_cnt_r, drop_cnt_r, aux_cnt_r;

    logic [47:0] eff_mac_s;
    logic [31:0] eff_ip_s;
    logic        abort_s, hdr_bad_s, crc_ok_s;
    logic [10:0] hdr_last_s;
    rx_state_t   hdr_next_s;
    logic        cnt_clr_s, cnt_inc_s, crc_init_s, crc_en_s;
    logic        drop_inc_s, aux_inc_s, crc_inc_s;
    logic        wr_s, end_s, ok_s, y_ld_s, x_inc_s, line_hi_ld_s, line_ld_s;
    logic        ovf_set_s, extra_set_s;

    // The board id pulls the last address octet down so two boards can share a link.
    assign eff_mac_s = {MY_MAC[47:8], MY_MAC[7:0] - {7'd0, id_r}};
    assign eff_ip_s  = {MY_IP[31:8],  MY_IP[7:0]  - {7'd0, id_r}};
    assign abort_s   = ~dv_r | er_r;

    // Input stage: every pin is retimed once before the parser looks at it.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) begin
            dv_r   <= 1'b0;
            er_r   <= 1'b0;
            full_r <= 1'b0;
            id_r   <= 1'b0;
            d_r    <= 8'h00;
        end else begin
            dv_r   <= rx_dv;
            er_r   <= rx_er;
            full_r <= full;
            id_r   <= id;
            d_r    <= rxd;
        end
    end

    crc32_chk u_crc (
        .clk    (rx_clk),
        .rst    (sys_rst),
        .init   (crc_init_s),
        .en     (crc_en_s),
        .data   (d_r),
        .crc_ok (crc_ok_s)
    );

    // Header field checks: flags the current byte if it breaks addressing or protocol.
    always_comb begin
        hdr_bad_s  = 1'b0;
        hdr_last_s = 11'd0;
        hdr_next_s = ST_DROP;
        case (state_r)
            ST_ETH: begin
                hdr_last_s = 11'd13;
                hdr_next_s = ST_IP;
                if (cnt_r < 11'd6)        hdr_bad_s = (d_r != mac_byte(eff_mac_s, cnt_r[2:0]));
                else if (cnt_r == 11'd12) hdr_bad_s = (d_r != ETHERTYPE_IP[15:8]);
                else if (cnt_r == 11'd13) hdr_bad_s = (d_r != ETHERTYPE_IP[7:0]);
                else                      hdr_bad_s = 1'b0;
            end
            ST_IP: begin
                hdr_last_s = 11'd19;
                hdr_next_s = ST_UDP;
                if (cnt_r == 11'd0)       hdr_bad_s = (d_r != IP_VER_IHL);
                else if (cnt_r == 11'd9)  hdr_bad_s = (d_r != IP_PROT_UDP);
                else if (cnt_r >= 11'd16) hdr_bad_s = (d_r != ip_byte(eff_ip_s, cnt_r[1:0]));
                else                      hdr_bad_s = 1'b0;
            end
            ST_UDP: begin
                hdr_last_s = 11'd7;
                hdr_next_s = ST_TYPE;
                if (cnt_r == 11'd2)       hdr_bad_s = (d_r != UDP_PORT[15:8]);
                else if (cnt_r == 11'd3)  hdr_bad_s = (d_r != UDP_PORT[7:0]);
                else                      hdr_bad_s = 1'b0;
            end
            default: begin
                hdr_bad_s = 1'b0;
            end
        endcase
    end

    // Parser next-state and per-byte control strobes.
    always_comb begin
        state_n_s    = state_r;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        crc_init_s   = 1'b0;
        crc_en_s     = 1'b0;
        drop_inc_s   = 1'b0;
        aux_inc_s    = 1'b0;
        crc_inc_s    = 1'b0;
        wr_s         = 1'b0;
        end_s        = 1'b0;
        ok_s         = 1'b0;
        y_ld_s       = 1'b0;
        x_inc_s      = 1'b0;
        line_hi_ld_s = 1'b0;
        line_ld_s    = 1'b0;
        ovf_set_s    = 1'b0;
        extra_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dv_r && (d_r == PREAMBLE)) state_n_s = ST_PRE;
                else                           state_n_s = ST_IDLE;
            end
            ST_PRE: begin
                if (abort_s) begin
                    state_n_s = dv_r ? ST_DROP : ST_IDLE;
                end else if (d_r == SFD) begin
                    state_n_s  = ST_ETH;
                    crc_init_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                end else if (d_r == PREAMBLE) begin
                    state_n_s = ST_PRE;
                end else begin
                    state_n_s = ST_DROP;
                end
            end
            ST_ETH, ST_IP, ST_UDP: begin
                if (abort_s) begin
                    state_n_s = dv_r ? ST_DROP : ST_IDLE;
                end else if (hdr_bad_s) begin
                    state_n_s  = ST_DROP;
                    drop_inc_s = 1'b1;
                end else begin
                    crc_en_s = 1'b1;
                    if (cnt_r == hdr_last_s) begin
                        state_n_s = hdr_next_s;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            ST_TYPE: begin
                if (abort_s) begin
                    state_n_s = dv_r ? ST_DROP : ST_IDLE;
                end else begin
                    crc_en_s = 1'b1;
                    case (d_r)
                        PKT_VIDEO: begin
                            state_n_s = ST_RESOL;
                            cnt_clr_s = 1'b1;
                        end
                        PKT_AUDIO, PKT_VIDAX: begin
                            state_n_s = ST_DROP;
                            aux_inc_s = 1'b1;
                        end
                        default: begin
                            state_n_s  = ST_DROP;
                            drop_inc_s = 1'b1;
                        end
                    endcase
                end
            end
            ST_RESOL: begin
                if (abort_s) begin
                    end_s     = 1'b1;
                    state_n_s = dv_r ? ST_DROP : ST_IDLE;
                end else begin
                    crc_en_s = 1'b1;
                    if (cnt_r == 11'd0) begin
                        line_hi_ld_s = 1'b1;
                        cnt_inc_s    = 1'b1;
                    end else if ({line_hi_r, d_r} > LINE_MAX) begin
                        state_n_s  = ST_DROP;
                        drop_inc_s = 1'b1;
                    end else begin
                        line_ld_s = 1'b1;
                        state_n_s = ST_PAYLOAD;
                        cnt_clr_s = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (abort_s) begin
                    end_s     = 1'b1;
                    state_n_s = dv_r ? ST_DROP : ST_IDLE;
                end else begin
                    crc_en_s = 1'b1;
                    // Even offsets carry Y, odd offsets carry C and complete a pixel.
                    if (!cnt_r[0]) begin
                        y_ld_s = 1'b1;
                    end else begin
                        x_inc_s = 1'b1;
                        if (full_r) ovf_set_s = 1'b1;
                        else        wr_s      = 1'b1;
                    end
                    if (cnt_r == (PAYLOAD_LEN - 11'd1)) begin
                        state_n_s = ST_FCS;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            ST_FCS: begin
                if (abort_s) begin
                    end_s     = 1'b1;
                    state_n_s = dv_r ? ST_DROP : ST_IDLE;
                end else begin
                    crc_en_s = 1'b1;
                    if (cnt_r == 11'd3) begin
                        state_n_s = ST_END;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            ST_END: begin
                if (!dv_r) begin
                    end_s     = 1'b1;
                    ok_s      = crc_ok_s & ~ovf_r & ~extra_r;
                    crc_inc_s = ~crc_ok_s;
                    state_n_s = ST_IDLE;
                end else begin
                    // Bytes past the FCS are not part of any valid frame.
                    extra_set_s = 1'b1;
                    state_n_s   = ST_END;
                end
            end
            ST_DROP: begin
                if (!dv_r) state_n_s = ST_IDLE;
                else       state_n_s = ST_DROP;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Parser state register.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) state_r <= ST_IDLE;
        else         state_r <= state_n_s;
    end

    // Byte counter, pixel position, line number and per-frame error flags.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) begin
            cnt_r     <= 11'd0;
            x_r       <= 11'd0;
            line_r    <= 11'd0;
            line_hi_r <= 3'd0;
            y_r       <= 8'h00;
            ovf_r     <= 1'b0;
            extra_r   <= 1'b0;
        end else begin
            if (cnt_clr_s)      cnt_r <= 11'd0;
            else if (cnt_inc_s) cnt_r <= cnt_r + 11'd1;
            else                cnt_r <= cnt_r;

            if (crc_init_s)   x_r <= 11'd0;
            else if (x_inc_s) x_r <= x_r + 11'd1;
            else              x_r <= x_r;

            if (line_ld_s) line_r <= {line_hi_r, d_r};
            else           line_r <= line_r;

            if (line_hi_ld_s) line_hi_r <= d_r[2:0];
            else              line_hi_r <= line_hi_r;

            if (y_ld_s) y_r <= d_r;
            else        y_r <= y_r;

            if (crc_init_s)     ovf_r <= 1'b0;
            else if (ovf_set_s) ovf_r <= 1'b1;
            else                ovf_r <= ovf_r;

            if (crc_init_s)       extra_r <= 1'b0;
            else if (extra_set_s) extra_r <= 1'b1;
            else                  extra_r <= extra_r;
        end
    end

    // FIFO write port and end-of-frame status, all driven from flops.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) begin
            wr_en_r   <= 1'b0;
            din_r     <= 38'd0;
            pkt_end_r <= 1'b0;
            pkt_ok_r  <= 1'b0;
        end else begin
            wr_en_r   <= wr_s;
            pkt_end_r <= end_s;
            pkt_ok_r  <= end_s & ok_s;
            if (wr_s) din_r <= {line_r, x_r, y_r, d_r};
            else      din_r <= din_r;
        end
    end

    // Saturating frame statistics.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) begin
            crc_err_cnt_r <= 16'd0;
            drop_cnt_r    <= 16'd0;
            aux_cnt_r     <= 16'd0;
        end else begin
            if (crc_inc_s)  crc_err_cnt_r <= sat_inc(crc_err_cnt_r);
            else            crc_err_cnt_r <= crc_err_cnt_r;
            if (drop_inc_s) drop_cnt_r    <= sat_inc(drop_cnt_r);
            else            drop_cnt_r    <= drop_cnt_r;
            if (aux_inc_s)  aux_cnt_r     <= sat_inc(aux_cnt_r);
            else            aux_cnt_r     <= aux_cnt_r;
        end
    end

    assign wr_en       = wr_en_r;
    assign din         = din_r;
    assign pkt_end     = pkt_end_r;
    assign pkt_ok      = pkt_ok_r;
    assign crc_err_cnt = crc_err_cnt_r;
    assign drop_cnt    = drop_cnt_r;
    assign aux_cnt     = aux_cnt_r;

endmodule

// File: tb/tb_gmii_rx_video.sv
// Directed bench for gmii_rx_video: builds complete frames (with an FCS
// computed by a reflected CRC-32 model) and checks FIFO writes and status.
module tb_gmii_rx_video;

    logic        rx_clk = 1'b0;
    logic        sys_rst, id, rx_dv, rx_er, full;
    logic [7:0]  rxd;
    logic        wr_en, pkt_end, pkt_ok;
    logic [37:0] din;
    logic [15:0] crc_err_cnt, drop_cnt, aux_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  fq[$];
    logic [37:0] wq[$];
    int          n_end = 0;
    logic        last_ok = 1'b0;

    localparam int PAY_OFS = 53;

    gmii_rx_video dut (
        .rx_clk      (rx_clk),
        .sys_rst     (sys_rst),
        .id          (id),
        .rx_dv       (rx_dv),
        .rx_er       (rx_er),
        .rxd         (rxd),
        .full        (full),
        .wr_en       (wr_en),
        .din         (din),
        .pkt_end     (pkt_end),
        .pkt_ok      (pkt_ok),
        .crc_err_cnt (crc_err_cnt),
        .drop_cnt    (drop_cnt),
        .aux_cnt     (aux_cnt)
    );

    always #4 rx_clk = ~rx_clk;

    // Collect FIFO writes and frame-end pulses away from the active edge.
    always @(negedge rx_clk) begin
        if (wr_en) wq.push_back(din);
        if (pkt_end) begin
            n_end++;
            last_ok = pkt_ok;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build_frame(input logic [7:0] mac_last, input logic [7:0] ip_last,
                               input logic [7:0] ptype, input logic [15:0] line, input int plen);
        logic [31:0] c;
        logic [7:0]  hdr[$];
        fq.delete();
        repeat (7) fq.push_back(8'h55);
        fq.push_back(8'hD5);
        hdr = '{8'h00, 8'h23, 8'h45, 8'h67, 8'h89, mac_last,
                8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00,
                8'h45, 8'h00, 8'h05, 8'h1F, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, ip_last,
                8'h30, 8'h39, 8'h30, 8'h39, 8'h05, 8'h0B, 8'h00, 8'h00,
                ptype, line[15:8], line[7:0]};
        foreach (hdr[i]) fq.push_back(hdr[i]);
        for (int p = 0; p < plen; p++) fq.push_back(8'(p));
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < fq.size(); i++) c = crc_ref(c, fq[i]);
        c = ~c;
        fq.push_back(c[7:0]);
        fq.push_back(c[15:8]);
        fq.push_back(c[23:16]);
        fq.push_back(c[31:24]);
    endtask

    task automatic send(input int n, input int f_from, input int f_to, input int gap, input bit hold);
        for (int i = 0; i < n; i++) begin
            @(negedge rx_clk);
            rx_dv = 1'b1;
            rxd   = fq[i];
            full  = (i >= f_from) && (i < f_to);
        end
        if (!hold) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge rx_clk);
                rx_dv = 1'b0;
                rxd   = 8'h00;
                full  = 1'b0;
            end
        end
    endtask

    task automatic clear_mon();
        wq.delete();
        n_end   = 0;
        last_ok = 1'b0;
    endtask

    function automatic logic [37:0] wq_at(input int k);
        if (k >= 0 && k < wq.size()) return wq[k];
        return 38'h3F_FFFF_FFFF;
    endfunction

    // Number of writes that differ from the expected pixel stream (x = sa, sb skipped).
    function automatic int seq_errs(input logic [10:0] line, input int sa, input int sb);
        int k = 0;
        int e = 0;
        for (int x = 0; x < 640; x++) begin
            if (x == sa || x == sb) continue;
            if (wq_at(k) !== {line, 11'(x), 8'(2 * x), 8'(2 * x + 1)}) e++;
            k++;
        end
        if (wq.size() != k) e++;
        return e;
    endfunction

    initial begin
        sys_rst = 1'b1; id = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; full = 1'b0; rxd = 8'h00;
        repeat (4) @(negedge rx_clk);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_din", din, 0);
        check_val("rst_pkt_end", pkt_end, 0);
        check_val("rst_pkt_ok", pkt_ok, 0);
        check_val("rst_cnts", {crc_err_cnt, drop_cnt, aux_cnt}, 0);
        sys_rst = 1'b0;
        repeat (4) @(negedge rx_clk);

        // Good frame, line 10
        clear_mon();
        build_frame(8'h02, 8'h02, 8'h00, 16'd10, 1280);
        send(fq.size(), 0, 0, 12, 1'b0);
        check_val("good_writes", wq.size(), 640);
        check_val("good_first", wq_at(0), {11'd10, 11'd0, 8'h00, 8'h01});
        check_val("good_last", wq_at(639), {11'd10, 11'd639, 8'hFE, 8'hFF});
        check_val("good_seq", seq_errs(11'd10, -1, -1), 0);
        check_val("good_end", n_end, 1);
        check_val("good_ok", last_ok, 1);
        check_val("good_cnts", {crc_err_cnt, drop_cnt, aux_cnt}, 0);

        // One payload byte flipped after the FCS was computed
        clear_mon();
        build_frame(8'h02, 8'h02, 8'h00, 16'd10, 1280);
        fq[PAY_OFS + 7] = fq[PAY_OFS + 7] ^ 8'hFF;
        send(fq.size(), 0, 0, 12, 1'b0);
        check_val("crc_writes", wq.size(), 640);
        check_val("crc_end", n_end, 1);
        check_val("crc_ok", last_ok, 0);
        check_val("crc_cnt", crc_err_cnt, 1);

        // id=1 expects MAC last octet 01; frame carries 02
        clear_mon();
        id = 1'b1;
        build_frame(8'h02, 8'h01, 8'h00, 16'd10, 1280);
        send(fq.size(), 0, 0, 12, 1'b0);
        check_val("mac_writes", wq.size(), 0);
        check_val("mac_end", n_end, 0);
        check_val("mac_drop", drop_cnt, 1);
        id = 1'b0;
        repeat (4) @(negedge rx_clk);

        // Audio frame, then a good video frame after a single idle cycle
        clear_mon();
        build_frame(8'h02, 8'h02, 8'h01, 16'd0, 16);
        send(fq.size(), 0, 0, 1, 1'b0);
        build_frame(8'h02, 8'h02, 8'h00, 16'd5, 1280);
        send(fq.size(), 0, 0, 12, 1'b0);
        check_val("aux_cnt", aux_cnt, 1);
        check_val("aux_writes", wq.size(), 640);
        check_val("aux_seq", seq_errs(11'd5, -1, -1), 0);
        check_val("aux_end", n_end, 1);
        check_val("aux_ok", last_ok, 1);

        // full high over payload bytes 100..104 removes pixels 50 and 51
        clear_mon();
        build_frame(8'h02, 8'h02, 8'h00, 16'd719, 1280);
        send(fq.size(), PAY_OFS + 100, PAY_OFS + 105, 12, 1'b0);
        check_val("ovf_writes", wq.size(), 638);
        check_val("ovf_seq", seq_errs(11'd719, 50, 51), 0);
        check_val("ovf_ok", last_ok, 0);
        check_val("ovf_end", n_end, 1);
        check_val("ovf_crc_cnt", crc_err_cnt, 1);

        // Line number above the limit is dropped
        clear_mon();
        build_frame(8'h02, 8'h02, 8'h00, 16'd720, 1280);
        send(fq.size(), 0, 0, 12, 1'b0);
        check_val("line_writes", wq.size(), 0);
        check_val("line_drop", drop_cnt, 2);

        // rx_dv drops after 100 payload bytes
        clear_mon();
        build_frame(8'h02, 8'h02, 8'h00, 16'd3, 1280);
        send(PAY_OFS + 100, 0, 0, 12, 1'b0);
        check_val("early_writes", wq.size(), 50);
        check_val("early_end", n_end, 1);
        check_val("early_ok", last_ok, 0);
        check_val("early_crc_cnt", crc_err_cnt, 1);

        // Reset in the middle of a payload, then a clean frame
        build_frame(8'h02, 8'h02, 8'h00, 16'd7, 1280);
        send(PAY_OFS + 200, 0, 0, 0, 1'b1);
        @(negedge rx_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge rx_clk);
        check_val("mid_rst_wr_en", wr_en, 0);
        check_val("mid_rst_din", din, 0);
        check_val("mid_rst_cnts", {crc_err_cnt, drop_cnt, aux_cnt}, 0);
        sys_rst = 1'b0;
        rx_dv   = 1'b0;
        rxd     = 8'h00;
        repeat (3) @(negedge rx_clk);
        clear_mon();
        send(fq.size(), 0, 0, 12, 1'b0);
        check_val("post_rst_writes", wq.size(), 640);
        check_val("post_rst_seq", seq_errs(11'd7, -1, -1), 0);
        check_val("post_rst_end", n_end, 1);
        check_val("post_rst_ok", last_ok, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
